// File: rtl/fir_demux_pkg.sv
// Shared constants and helpers for the FIR sample demultiplexer.
// The FIR_DEMUX_CH_W(n) macro gives the channel-index width for n channels.
`ifndef FIR_DEMUX_CH_W
`define FIR_DEMUX_CH_W(n) fir_demux_pkg::clog2(n)
`endif

package fir_demux_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_NUM_CH = 2;

    // Ceiling log2 with a floor of 1 so a channel index is never zero bits wide.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (remain > 0) begin
                result = result + 1;
                remain = remain >> 1;
            end else begin
                result = result;
            end
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_demux_slot.sv
// One-entry holding register for a single demux output channel.
module fir_demux_slot
    import fir_demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;

    // Load wins over drain so a same-cycle drain+load keeps valid high; data holds after drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/fir_sample_demux.sv
// 1-to-NUM_CH sample distributor with per-channel valid/ready holding registers.
// Optional build macro FIR_DEMUX_EXT_SEL_EN: destination comes from sel instead of round-robin.
module fir_sample_demux
    import fir_demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int CH_W   = `FIR_DEMUX_CH_W(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [CH_W-1:0]          ch_ptr,
    input  logic [CH_W-1:0]          sel,
    output logic                     sel_err
);

    localparam logic [CH_W:0]   NUM_CH_X = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]   ch_ptr_r;
    logic [CH_W-1:0]   dest_s;
    logic              dest_ok_s;
    logic              dest_busy_s;
    logic              accept_s;
    logic [NUM_CH-1:0] load_s;
    logic [NUM_CH-1:0] slot_valid_s;

`ifdef FIR_DEMUX_EXT_SEL_EN
    assign dest_s  = sel;
    assign sel_err = !rst && in_valid && !dest_ok_s;
`else
    logic unused_sel_s;
    assign unused_sel_s = ^sel;
    assign dest_s       = ch_ptr_r;
    assign sel_err      = 1'b0;
`endif

    assign dest_ok_s = ({1'b0, dest_s} < NUM_CH_X);
    assign in_ready  = !rst && dest_ok_s && !dest_busy_s;
    assign accept_s  = in_valid && in_ready;

    // Destination is busy only if it holds a sample its consumer is not taking this cycle.
    always_comb begin
        dest_busy_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (dest_s == CH_W'(k)) begin
                dest_busy_s = slot_valid_s[k] && !out_ready[k];
            end else begin
                dest_busy_s = dest_busy_s;
            end
        end
    end

    // One-hot load strobe for the accepted sample's destination slot.
    always_comb begin
        load_s = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (dest_s == CH_W'(k)) begin
                load_s[k] = accept_s;
            end else begin
                load_s[k] = 1'b0;
            end
        end
    end

    // Pointer follows the last accepted destination +1, wrapping at NUM_CH.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_ptr_r <= {CH_W{1'b0}};
        end else if (accept_s) begin
            ch_ptr_r <= (dest_s == LAST_CH) ? {CH_W{1'b0}} : dest_s + CH_W'(1);
        end else begin
            ch_ptr_r <= ch_ptr_r;
        end
    end

    assign ch_ptr    = ch_ptr_r;
    assign out_valid = slot_valid_s;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        fir_demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load_s[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (slot_valid_s[k]),
            .data      (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_fir_sample_demux.sv
// Directed bench for fir_sample_demux: 3-channel table plus 2-channel hand sequences.
module tb_fir_sample_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // NUM_CH = 3 instance
    logic        rst3;
    logic        vld3;
    logic [15:0] data3;
    logic [2:0]  ordy3;
    logic [1:0]  sel3;
    logic        rdy3;
    logic [47:0] od3;
    logic [2:0]  ov3;
    logic [1:0]  ptr3;
    logic        serr3;

    // NUM_CH = 2 instance
    logic        rst2;
    logic        vld2;
    logic [15:0] data2;
    logic [1:0]  ordy2;
    logic [0:0]  sel2;
    logic        rdy2;
    logic [31:0] od2;
    logic [1:0]  ov2;
    logic [0:0]  ptr2;
    logic        serr2;

    fir_sample_demux #(.DATA_W(16), .NUM_CH(3)) u_dut3 (
        .clk(clk), .rst(rst3), .in_data(data3), .in_valid(vld3), .in_ready(rdy3),
        .out_data(od3), .out_valid(ov3), .out_ready(ordy3), .ch_ptr(ptr3),
        .sel(sel3), .sel_err(serr3)
    );

    fir_sample_demux #(.DATA_W(16), .NUM_CH(2)) u_dut2 (
        .clk(clk), .rst(rst2), .in_data(data2), .in_valid(vld2), .in_ready(rdy2),
        .out_data(od2), .out_valid(ov2), .out_ready(ordy2), .ch_ptr(ptr2),
        .sel(sel2), .sel_err(serr2)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] data;
        logic [2:0]  ordy;
        logic        exp_rdy;
        logic [1:0]  exp_ptr;
        logic [2:0]  exp_ov;
        logic [47:0] exp_od;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [15:0] d,
                                input logic [2:0] o, input logic er, input logic [1:0] ep,
                                input logic [2:0] eov, input logic [15:0] e2,
                                input logic [15:0] e1, input logic [15:0] e0);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.ordy = o;
        t.exp_rdy = er; t.exp_ptr = ep; t.exp_ov = eov; t.exp_od = {e2, e1, e0};
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive2(input logic r, input logic v, input logic [15:0] d, input logic [1:0] o);
        @(negedge clk);
        rst2 = r; vld2 = v; data2 = d; ordy2 = o;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst3 = 1'b1; vld3 = 1'b0; data3 = 16'h0000; ordy3 = 3'b000; sel3 = 2'd0;
        rst2 = 1'b1; vld2 = 1'b0; data2 = 16'h0000; ordy2 = 2'b00;  sel2 = 1'b0;
        repeat (2) @(posedge clk);

        // Reset with traffic present on the 2-channel instance
        drive2(1'b1, 1'b1, 16'hBEEF, 2'b11);
        chk("rst2 in_ready", rdy2, 1'b0);
        tick();
        chk("rst2 out_valid", ov2, 2'b00);
        chk("rst2 out_data", od2, 32'h0);
        chk("rst2 ch_ptr", ptr2, 1'b0);

`ifndef FIR_DEMUX_EXT_SEL_EN
        //            rst  vld  data      ordy    rdy  ptr ov      ch2       ch1       ch0
        tbl.push_back(mk(1'b1, 1'b1, 16'hDEAD, 3'b111, 1'b0, 2'd0, 3'b000, 16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0001, 3'b111, 1'b1, 2'd1, 3'b001, 16'h0000, 16'h0000, 16'h0001));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0002, 3'b111, 1'b1, 2'd2, 3'b010, 16'h0000, 16'h0002, 16'h0001));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0003, 3'b111, 1'b1, 2'd0, 3'b100, 16'h0003, 16'h0002, 16'h0001));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0004, 3'b111, 1'b1, 2'd1, 3'b001, 16'h0003, 16'h0002, 16'h0004));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0005, 3'b111, 1'b1, 2'd2, 3'b010, 16'h0003, 16'h0005, 16'h0004));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0006, 3'b111, 1'b1, 2'd0, 3'b100, 16'h0006, 16'h0005, 16'h0004));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0007, 3'b111, 1'b1, 2'd1, 3'b001, 16'h0006, 16'h0005, 16'h0007));
        tbl.push_back(mk(1'b0, 1'b0, 16'hFFFF, 3'b111, 1'b1, 2'd1, 3'b000, 16'h0006, 16'h0005, 16'h0007));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0011, 3'b000, 1'b1, 2'd2, 3'b010, 16'h0006, 16'h0011, 16'h0007));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0022, 3'b000, 1'b1, 2'd0, 3'b110, 16'h0022, 16'h0011, 16'h0007));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0033, 3'b000, 1'b1, 2'd1, 3'b111, 16'h0022, 16'h0011, 16'h0033));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0044, 3'b000, 1'b0, 2'd1, 3'b111, 16'h0022, 16'h0011, 16'h0033));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0055, 3'b010, 1'b1, 2'd2, 3'b111, 16'h0022, 16'h0055, 16'h0033));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0066, 3'b000, 1'b0, 2'd0, 3'b000, 16'h0000, 16'h0000, 16'h0000));
        tbl.push_back(mk(1'b0, 1'b1, 16'h0077, 3'b000, 1'b1, 2'd1, 3'b001, 16'h0000, 16'h0000, 16'h0077));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 3'b110, 1'b1, 2'd1, 3'b001, 16'h0000, 16'h0000, 16'h0077));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 3'b001, 1'b1, 2'd1, 3'b000, 16'h0000, 16'h0000, 16'h0077));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst3 = tbl[i].rst; vld3 = tbl[i].vld; data3 = tbl[i].data; ordy3 = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), rdy3, tbl[i].exp_rdy);
            tick();
            chk($sformatf("v%0d ch_ptr", i), ptr3, tbl[i].exp_ptr);
            chk($sformatf("v%0d out_valid", i), ov3, tbl[i].exp_ov);
            chk($sformatf("v%0d out_data", i), od3, tbl[i].exp_od);
        end
        chk("sel_err tied low", serr3, 1'b0);

        // Round-robin on two channels, consumers always ready
        drive2(1'b0, 1'b1, 16'h0001, 2'b11);
        chk("rr s1 in_ready", rdy2, 1'b1);
        chk("rr s1 ch_ptr", ptr2, 1'b0);
        tick();
        chk("rr s1 out_valid", ov2, 2'b01);
        chk("rr s1 out_data", od2, 32'h0000_0001);
        drive2(1'b0, 1'b1, 16'h0002, 2'b11);
        chk("rr s2 in_ready", rdy2, 1'b1);
        chk("rr s2 ch_ptr", ptr2, 1'b1);
        tick();
        chk("rr s2 out_valid", ov2, 2'b10);
        chk("rr s2 out_data", od2, 32'h0002_0001);
        drive2(1'b0, 1'b1, 16'h0003, 2'b11);
        chk("rr s3 in_ready", rdy2, 1'b1);
        chk("rr s3 ch_ptr", ptr2, 1'b0);
        tick();
        chk("rr s3 out_valid", ov2, 2'b01);
        chk("rr s3 out_data", od2, 32'h0002_0003);
        chk("rr s3 ch_ptr", ptr2, 1'b1);

        // Back-pressure: both channels full, third sample stalls until ch0 drains
        drive2(1'b1, 1'b0, 16'h0000, 2'b00);
        tick();
        drive2(1'b0, 1'b1, 16'hAAAA, 2'b00);
        chk("bp a in_ready", rdy2, 1'b1);
        tick();
        drive2(1'b0, 1'b1, 16'h5555, 2'b00);
        chk("bp b in_ready", rdy2, 1'b1);
        tick();
        chk("bp full out_valid", ov2, 2'b11);
        chk("bp full out_data", od2, 32'h5555_AAAA);
        drive2(1'b0, 1'b1, 16'h0F0F, 2'b00);
        chk("bp stall in_ready", rdy2, 1'b0);
        chk("bp stall ch_ptr", ptr2, 1'b0);
        tick();
        chk("bp stall out_data", od2, 32'h5555_AAAA);
        drive2(1'b0, 1'b1, 16'h0F0F, 2'b01);
        chk("bp release in_ready", rdy2, 1'b1);
        tick();
        chk("bp release out_valid", ov2, 2'b11);
        chk("bp release out_data", od2, 32'h5555_0F0F);
        chk("bp release ch_ptr", ptr2, 1'b1);
`else
        // External select on the 3-channel instance
        @(negedge clk);
        rst3 = 1'b1; vld3 = 1'b0;
        tick();
        @(negedge clk);
        rst3 = 1'b0; vld3 = 1'b1; data3 = 16'h1234; sel3 = 2'd2; ordy3 = 3'b000;
        #1;
        chk("sel2 in_ready", rdy3, 1'b1);
        chk("sel2 sel_err", serr3, 1'b0);
        tick();
        chk("sel2 out_valid", ov3, 3'b100);
        chk("sel2 out_data", od3, {16'h1234, 16'h0000, 16'h0000});
        chk("sel2 ch_ptr", ptr3, 2'd0);
        @(negedge clk);
        data3 = 16'h9999; sel3 = 2'd3;
        #1;
        chk("sel3 in_ready", rdy3, 1'b0);
        chk("sel3 sel_err", serr3, 1'b1);
        tick();
        chk("sel3 out_valid", ov3, 3'b100);
        chk("sel3 out_data", od3, {16'h1234, 16'h0000, 16'h0000});
        chk("sel3 ch_ptr", ptr3, 2'd0);
        @(negedge clk);
        data3 = 16'h4242; sel3 = 2'd0;
        #1;
        chk("sel0 in_ready", rdy3, 1'b1);
        tick();
        chk("sel0 out_valid", ov3, 3'b101);
        chk("sel0 out_data", od3, {16'h1234, 16'h0000, 16'h4242});
        chk("sel0 ch_ptr", ptr3, 2'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
